// File: rtl/debug_uart_sink_pkg.sv
// Shared types, default addresses and helpers for the debug UART sink.
package debug_uart_sink_pkg;

  typedef enum logic [1:0] {
    RUN,
    DRAIN,
    DONE
  } sink_state_t;

  localparam logic [31:0] DEBUG_ADDR_DEF = 32'hf00000d0;
  localparam logic [31:0] EXIT_ADDR_DEF  = 32'hf00000d4;

  // Index of the lowest enabled byte lane; 0 when no lane is enabled.
  function automatic logic [1:0] lowest_lane(logic [3:0] wbe);
    logic [1:0] lane;
    if (wbe[0])      lane = 2'd0;
    else if (wbe[1]) lane = 2'd1;
    else if (wbe[2]) lane = 2'd2;
    else if (wbe[3]) lane = 2'd3;
    else             lane = 2'd0;
    return lane;
  endfunction

endpackage

// File: rtl/debug_uart_sink_if.sv
// Core data-bus snoop inputs plus the valid/ready byte stream of the debug UART sink.
interface debug_uart_sink_if;

  logic        bus_access;
  logic [31:0] bus_addr;
  logic [31:0] bus_wdata;
  logic [3:0]  bus_wbe;
  logic        tx_valid;
  logic [7:0]  tx_data;
  logic        tx_ready;

  modport master (
    output bus_access, bus_addr, bus_wdata, bus_wbe, tx_ready,
    input  tx_valid, tx_data
  );

  modport slave (
    input  bus_access, bus_addr, bus_wdata, bus_wbe, tx_ready,
    output tx_valid, tx_data
  );

endinterface

// File: rtl/debug_sink_fifo.sv
// First-word-fall-through byte FIFO; a push while full is accepted only alongside a pop.
module debug_sink_fifo #(
  parameter int unsigned Depth = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   push_i,
  input  logic [7:0]             wdata_i,
  input  logic                   pop_i,
  output logic [7:0]             rdata_o,
  output logic                   full_o,
  output logic                   empty_o,
  output logic [$clog2(Depth):0] level_o
);

  localparam int unsigned AddrW = $clog2(Depth);
  localparam int unsigned LvlW  = AddrW + 1;

  logic [7:0]       mem_q [Depth];
  logic [AddrW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AddrW-1:0] rd_ptr_q, rd_ptr_d;
  logic [LvlW-1:0]  count_q, count_d;
  logic             push_ok, pop_ok;

  assign full_o  = (count_q == LvlW'(Depth));
  assign empty_o = (count_q == '0);
  assign pop_ok  = pop_i && !empty_o;
  assign push_ok = push_i && (!full_o || pop_ok);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    // Power-of-two depth: pointers wrap naturally.
    if (push_ok) wr_ptr_d = wr_ptr_q + AddrW'(1);
    if (pop_ok)  rd_ptr_d = rd_ptr_q + AddrW'(1);
    if (push_ok && !pop_ok) count_d = count_q + LvlW'(1);
    if (pop_ok && !push_ok) count_d = count_q - LvlW'(1);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= wdata_i;
  end

  assign rdata_o = empty_o ? 8'h00 : mem_q[rd_ptr_q];
  assign level_o = count_q;

endmodule

// File: rtl/debug_uart_sink.sv
// Snoops debug-UART and exit stores, buffers characters, and flags exit once output has drained.
module debug_uart_sink
  import debug_uart_sink_pkg::*;
#(
  parameter logic [31:0] DEBUG_ADDR = DEBUG_ADDR_DEF,
  parameter logic [31:0] EXIT_ADDR  = EXIT_ADDR_DEF,
  parameter int unsigned FIFO_DEPTH = 16,
  parameter int unsigned CNT_W      = 16
) (
  input  logic                        clk,
  input  logic                        reset,
  debug_uart_sink_if.slave            bus,
  output logic [$clog2(FIFO_DEPTH):0] level,
  output logic                        overflow,
  output logic [CNT_W-1:0]            drop_count,
  output logic [CNT_W-1:0]            line_count,
  output logic                        exit_valid,
  output logic [31:0]                 exit_code
);

  sink_state_t      state_q, state_d;
  logic             overflow_q, overflow_d;
  logic [CNT_W-1:0] drop_count_q, drop_count_d;
  logic [CNT_W-1:0] line_count_q, line_count_d;
  logic             exit_valid_q, exit_valid_d;
  logic [31:0]      exit_code_q, exit_code_d;

  logic       is_write, capture, exit_hit, pop;
  logic [1:0] lane;
  logic [7:0] cap_byte, head_byte;
  logic       fifo_full, fifo_empty;

  assign is_write = bus.bus_access && (bus.bus_wbe != 4'b0000);
  assign capture  = (state_q == RUN) && is_write && (bus.bus_addr == DEBUG_ADDR);
  assign exit_hit = (state_q == RUN) && is_write && (bus.bus_addr == EXIT_ADDR);
  assign lane     = lowest_lane(bus.bus_wbe);
  assign pop      = !fifo_empty && bus.tx_ready;

  always_comb begin
    unique case (lane)
      2'd0:    cap_byte = bus.bus_wdata[7:0];
      2'd1:    cap_byte = bus.bus_wdata[15:8];
      2'd2:    cap_byte = bus.bus_wdata[23:16];
      default: cap_byte = bus.bus_wdata[31:24];
    endcase
  end

  debug_sink_fifo #(
    .Depth (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .push_i  (capture),
    .wdata_i (cap_byte),
    .pop_i   (bus.tx_ready),
    .rdata_o (head_byte),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .level_o (level)
  );

  always_comb begin
    state_d      = state_q;
    overflow_d   = overflow_q;
    drop_count_d = drop_count_q;
    line_count_d = line_count_q;
    exit_code_d  = exit_code_q;
    case (state_q)
      RUN: begin
        if (exit_hit) begin
          state_d     = DRAIN;
          exit_code_d = bus.bus_wdata;
        end
      end
      // Level seen at the edge, so DONE follows the cycle in which the FIFO reads empty.
      DRAIN:   if (level == '0) state_d = DONE;
      DONE:    state_d = DONE;
      default: state_d = RUN;
    endcase
    exit_valid_d = (state_d == DONE);
    if (capture && fifo_full && !pop) begin
      overflow_d = 1'b1;
      if (drop_count_q != '1) drop_count_d = drop_count_q + CNT_W'(1);
    end
    if (pop && (head_byte == 8'h0A)) line_count_d = line_count_q + CNT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= RUN;
      overflow_q   <= 1'b0;
      drop_count_q <= '0;
      line_count_q <= '0;
      exit_valid_q <= 1'b0;
      exit_code_q  <= '0;
    end else begin
      state_q      <= state_d;
      overflow_q   <= overflow_d;
      drop_count_q <= drop_count_d;
      line_count_q <= line_count_d;
      exit_valid_q <= exit_valid_d;
      exit_code_q  <= exit_code_d;
    end
  end

  assign bus.tx_valid = !fifo_empty;
  assign bus.tx_data  = head_byte;
  assign overflow     = overflow_q;
  assign drop_count   = drop_count_q;
  assign line_count   = line_count_q;
  assign exit_valid   = exit_valid_q;
  assign exit_code    = exit_code_q;

endmodule

// File: tb/tb_debug_uart_sink.sv
// Directed, table-driven bench for debug_uart_sink with hand-written multi-cycle sequences.
module tb_debug_uart_sink;
  import debug_uart_sink_pkg::*;

  localparam logic [31:0] DA = DEBUG_ADDR_DEF;
  localparam logic [31:0] EA = EXIT_ADDR_DEF;

  logic        clk = 1'b0;
  logic        reset;
  logic [4:0]  level;
  logic        overflow;
  logic [15:0] drop_count;
  logic [15:0] line_count;
  logic        exit_valid;
  logic [31:0] exit_code;

  int passed = 0;
  int total  = 0;

  always #5 clk = ~clk;

  debug_uart_sink_if bus_if ();

  debug_uart_sink #(
    .DEBUG_ADDR (DA),
    .EXIT_ADDR  (EA),
    .FIFO_DEPTH (16),
    .CNT_W      (16)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .bus        (bus_if),
    .level      (level),
    .overflow   (overflow),
    .drop_count (drop_count),
    .line_count (line_count),
    .exit_valid (exit_valid),
    .exit_code  (exit_code)
  );

  typedef struct {
    logic        acc;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wbe;
    logic        rdy;
    logic        exp_valid;
    logic [7:0]  exp_data;
    logic [4:0]  exp_level;
    logic [15:0] exp_lines;
  } vec_t;

  vec_t vecs [12];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) $display("FAIL %s: got %h, expected %h", name, act, exp);
    else passed++;
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic acc, input logic [31:0] a, input logic [31:0] d,
                       input logic [3:0] w, input logic rdy);
    bus_if.bus_access = acc;
    bus_if.bus_addr   = a;
    bus_if.bus_wdata  = d;
    bus_if.bus_wbe    = w;
    bus_if.tx_ready   = rdy;
  endtask

  task automatic idle(input logic rdy);
    drive(1'b0, 32'h0, 32'h0, 4'b0000, rdy);
  endtask

  task automatic wr_char(input logic [7:0] b, input logic rdy);
    drive(1'b1, DA, {24'h0, b}, 4'b0001, rdy);
  endtask

  task automatic do_reset();
    idle(1'b0);
    reset = 1'b1;
    cyc();
    reset = 1'b0;
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, " tx_valid"}, {31'h0, bus_if.tx_valid}, 32'h0);
    check({tag, " tx_data"}, {24'h0, bus_if.tx_data}, 32'h0);
    check({tag, " level"}, {27'h0, level}, 32'h0);
    check({tag, " ovf/drop/line"}, {overflow, drop_count[14:0], line_count}, 32'h0);
    check({tag, " exit_valid"}, {31'h0, exit_valid}, 32'h0);
    check({tag, " exit_code"}, exit_code, 32'h0);
  endtask

  initial begin
    logic [7:0] exp_b;
    logic [7:0] okn [3];

    vecs[0]  = '{1'b1, DA, 32'h00480000, 4'b0100, 1'b1, 1'b1, 8'h48, 5'd1, 16'd0};
    vecs[1]  = '{1'b0, 32'h0, 32'h0, 4'b0000, 1'b1, 1'b0, 8'h00, 5'd0, 16'd0};
    vecs[2]  = '{1'b1, DA, 32'h44434241, 4'b1111, 1'b0, 1'b1, 8'h41, 5'd1, 16'd0};
    vecs[3]  = '{1'b1, DA, 32'h5A000000, 4'b1000, 1'b0, 1'b1, 8'h41, 5'd2, 16'd0};
    vecs[4]  = '{1'b1, DA, 32'h00000077, 4'b0000, 1'b0, 1'b1, 8'h41, 5'd2, 16'd0};
    vecs[5]  = '{1'b1, 32'hf00000d1, 32'h00000077, 4'b0001, 1'b0, 1'b1, 8'h41, 5'd2, 16'd0};
    vecs[6]  = '{1'b0, DA, 32'h00000077, 4'b1111, 1'b0, 1'b1, 8'h41, 5'd2, 16'd0};
    vecs[7]  = '{1'b0, 32'h0, 32'h0, 4'b0000, 1'b1, 1'b1, 8'h5A, 5'd1, 16'd0};
    vecs[8]  = '{1'b1, DA, 32'h0000000A, 4'b0001, 1'b1, 1'b1, 8'h0A, 5'd1, 16'd0};
    vecs[9]  = '{1'b0, 32'h0, 32'h0, 4'b0000, 1'b1, 1'b0, 8'h00, 5'd0, 16'd1};
    vecs[10] = '{1'b1, DA, 32'h00000A00, 4'b0110, 1'b0, 1'b1, 8'h0A, 5'd1, 16'd1};
    vecs[11] = '{1'b0, 32'h0, 32'h0, 4'b0000, 1'b1, 1'b0, 8'h00, 5'd0, 16'd2};

    do_reset();
    check_reset_state("reset");

    for (int i = 0; i < 12; i++) begin
      drive(vecs[i].acc, vecs[i].addr, vecs[i].wdata, vecs[i].wbe, vecs[i].rdy);
      cyc();
      check($sformatf("vec%0d valid/data/level/lines", i),
            {2'b00, bus_if.tx_valid, bus_if.tx_data, level, line_count},
            {2'b00, vecs[i].exp_valid, vecs[i].exp_data, vecs[i].exp_level, vecs[i].exp_lines});
    end

    // Backpressure: 20 writes into a 16-deep FIFO.
    for (int i = 0; i < 20; i++) begin
      wr_char(8'(8'h60 + i), 1'b0);
      cyc();
    end
    idle(1'b0);
    check("ovf level", {27'h0, level}, 32'd16);
    check("ovf flag", {31'h0, overflow}, 32'd1);
    check("ovf drop_count", {16'h0, drop_count}, 32'd4);
    check("ovf head", {23'h0, bus_if.tx_valid, bus_if.tx_data}, {23'h0, 1'b1, 8'h60});

    // Capture coinciding with a pop while full.
    wr_char(8'hEE, 1'b1);
    cyc();
    check("full+pop level", {27'h0, level}, 32'd16);
    check("full+pop drop_count", {16'h0, drop_count}, 32'd4);

    idle(1'b1);
    for (int k = 0; k < 16; k++) begin
      exp_b = (k < 15) ? 8'(8'h61 + k) : 8'hEE;
      check($sformatf("drain byte%0d", k), {23'h0, bus_if.tx_valid, bus_if.tx_data},
            {23'h0, 1'b1, exp_b});
      cyc();
    end
    check("drain empty", {26'h0, bus_if.tx_valid, level}, 32'h0);
    check("drain lines", {16'h0, line_count}, 32'd2);

    // Exit with buffered output.
    do_reset();
    okn[0] = 8'h6F;
    okn[1] = 8'h6B;
    okn[2] = 8'h0A;
    for (int i = 0; i < 3; i++) begin
      wr_char(okn[i], 1'b0);
      cyc();
    end
    drive(1'b1, EA, 32'h0000_0007, 4'b1111, 1'b0);
    cyc();
    check("exit pending", {31'h0, exit_valid}, 32'd0);
    check("exit code", exit_code, 32'd7);
    wr_char(8'h58, 1'b0);
    cyc();
    check("drain ignores char", {27'h0, level}, 32'd3);
    drive(1'b1, EA, 32'h0000_0009, 4'b1111, 1'b0);
    cyc();
    check("exit code frozen", exit_code, 32'd7);
    idle(1'b1);
    for (int i = 0; i < 3; i++) begin
      check($sformatf("exit byte%0d", i), {23'h0, bus_if.tx_valid, bus_if.tx_data},
            {23'h0, 1'b1, okn[i]});
      cyc();
    end
    check("exit drained level", {27'h0, level}, 32'd0);
    check("exit line_count", {16'h0, line_count}, 32'd1);
    check("exit_valid at empty", {31'h0, exit_valid}, 32'd0);
    cyc();
    check("exit_valid after empty", {31'h0, exit_valid}, 32'd1);
    check("exit code final", exit_code, 32'd7);

    // Reset while draining with bytes buffered.
    do_reset();
    for (int i = 0; i < 5; i++) begin
      wr_char(8'(8'h30 + i), 1'b0);
      cyc();
    end
    drive(1'b1, EA, 32'h0000_00AB, 4'b1111, 1'b0);
    cyc();
    check("pre-reset level", {27'h0, level}, 32'd5);
    do_reset();
    check_reset_state("mid reset");
    wr_char(8'h33, 1'b0);
    cyc();
    check("post-reset capture", {18'h0, bus_if.tx_valid, bus_if.tx_data, level},
          {18'h0, 1'b1, 8'h33, 5'd1});
    idle(1'b1);
    cyc();
    check("post-reset pop", {27'h0, level}, 32'd0);

    // Exit with an empty FIFO.
    drive(1'b1, EA, 32'h12345678, 4'b0001, 1'b0);
    cyc();
    check("empty exit pending", {31'h0, exit_valid}, 32'd0);
    check("empty exit code", exit_code, 32'h12345678);
    idle(1'b0);
    cyc();
    check("empty exit valid", {31'h0, exit_valid}, 32'd1);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/debug_uart_sink.md
Name: debug_uart_sink

Overview:
- RTL peripheral that snoops the hfrv core data bus for stores to the debug UART address and the exit address.
- Captured characters are buffered in a FIFO and streamed as bytes over a valid/ready port. Both the debug UART monitor and an on-chip sink drain this port.
- Also latches the program exit code and raises an exit indication once all buffered output has drained. The testbench uses this to end simulation.

Parameters:
- DEBUG_ADDR, 32'hf00000d0, store address whose low byte is a character.
- EXIT_ADDR, 32'hf00000d4, store address whose 32-bit data is the exit code.
- FIFO_DEPTH, 16, byte entries; power of two, at least 2.
- CNT_W, 16, width of the drop and line counters.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- bus_access  in  1  core data access strobe this cycle.
- bus_addr  in  32  data address.
- bus_wdata  in  32  store data.
- bus_wbe  in  4  byte write enables; bit i covers wdata[8i+7:8i].
- tx_valid  out  1  head byte available.
- tx_data  out  8  head byte.
- tx_ready  in  1  consumer accepts the head byte.
- level  out  $clog2(FIFO_DEPTH)+1  FIFO occupancy.
- overflow  out  1  sticky: at least one character was dropped.
- drop_count  out  CNT_W  dropped characters, saturating.
- line_count  out  CNT_W  8'h0A bytes delivered, wrapping.
- exit_valid  out  1  exit reached and FIFO drained; held high.
- exit_code  out  32  latched exit data.

Behaviour:
- Reset: one clk edge with reset=1 produces the following.
  - FIFO empty; tx_valid=0, tx_data=0, level=0.
  - overflow=0, drop_count=0, line_count=0.
  - exit_valid=0, exit_code=0, state=RUN.
  - Reset mid-stream discards all buffered bytes.
- Write decode: a write occurs when bus_access=1 and bus_wbe!=0. Reads (wbe=0) are ignored.
- Char capture (state RUN, write, bus_addr==DEBUG_ADDR):
  - Lane = lowest-indexed set bit of bus_wbe; byte = bus_wdata[8*lane+7 -: 8].
  - Word or halfword stores yield exactly one byte, taken from the lowest enabled lane.
- Push/pop:
  - Push at the capture edge. FWFT: tx_valid=1 and tx_data=byte from the next cycle (1-cycle latency).
  - Pop at any edge with tx_valid && tx_ready.
  - tx_data holds stable while tx_valid=1 and tx_ready=0.
- Full: a capture with level==FIFO_DEPTH and no simultaneous pop drops the byte.
  - overflow is set and drop_count increments, saturating at all-ones.
  - A capture coinciding with a pop while full is accepted; level is unchanged.
- Empty: a simultaneous capture and tx_ready has no pop (tx_valid=0); level becomes 1.
- Pointers wrap modulo FIFO_DEPTH.
- level reflects the post-edge occupancy; push and pop in the same cycle leave it unchanged.
- line_count increments on each pop whose byte is 8'h0A; it wraps at 2^CNT_W.
- State machine:
  - RUN -> DRAIN on a write to EXIT_ADDR; exit_code <= bus_wdata in full, independent of wbe.
  - If DEBUG_ADDR and EXIT_ADDR writes are impossible in the same cycle (one address per cycle), no tie-break is needed.
  - DRAIN -> DONE at the first edge where level==0 after any pop; exit_valid=1 from the following cycle.
  - In DRAIN and DONE, writes to DEBUG_ADDR and EXIT_ADDR are ignored: no capture, no drop count, exit_code frozen.
  - DONE is terminal until reset.
  - Exit with an empty FIFO: DRAIN lasts one cycle, so exit_valid rises 2 cycles after the exit store.
- bus_addr compares are exact 32-bit; no address masking.

Decomposition:
- Package debug_uart_sink_pkg holds:
  - state enum sink_state_t {RUN, DRAIN, DONE};
  - default address constants DEBUG_ADDR_DEF and EXIT_ADDR_DEF;
  - function lowest_lane(logic [3:0]) returning a 2-bit lane index.
- One sub-module, debug_sink_fifo: parameterised FWFT byte FIFO with push/pop/full/empty/level.
- Capture decode, counters and the FSM stay in the top module.

Test Plan:
- Single char: sb 8'h48 to DEBUG_ADDR with wbe=4'b0100, wdata=32'h00480000, tx_ready=1 -> tx_valid high 1 cycle later with tx_data=8'h48; level returns to 0.
- Lane select: sw wdata=32'h44434241, wbe=4'b1111 -> exactly one byte 8'h41. Separately, wbe=4'b1000 with wdata=32'h5A000000 -> byte 8'h5A.
- Backpressure/overflow, FIFO_DEPTH=16, tx_ready=0:
  - 20 char writes -> level=16, overflow=1, drop_count=4.
  - Then tx_ready=1 -> the first 16 bytes are delivered in order; the 4 late bytes never appear.
- Full plus simultaneous pop: at level=16, capture and pop in the same cycle -> level stays 16, drop_count unchanged, new byte delivered last.
- Exit drain:
  - Queue "ok\n" with tx_ready=0, then store 32'h0000_0007 to EXIT_ADDR -> exit_valid stays 0.
  - A later char write is ignored.
  - Release tx_ready -> 3 bytes delivered, line_count=1, exit_valid=1 the cycle after level hits 0, exit_code=7.
- Reset mid-operation: with level=5 and state=DRAIN, assert reset for 1 cycle -> all outputs return to reset values and state=RUN; a subsequent char write is captured normally.
